hub75_scan: RTL and testbench

- Display-side reader of the two half-frame pixel memories that the paint controller writes.
- Continuously scans memory 0 (rows 0..31) and memory 1 (rows 32..63) in parallel through the memory read ports.
- Converts each 12-bit pixel into 4-plane binary-code-modulated RGB.
- Drives a HUB75 64x64 LED panel: shift clock, latch, output enable, row address.

---
 rtl/hub75_scan.sv | 137 +++++++++++++
 tb/tb_hub75_scan.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan.sv
// hub75_scan: scans both half-frame pixel memories and drives a HUB75 64x64 panel with 4-plane BCM.
// Optional build macro HUB75_INVERT_EN: memories hold inverted pixel data (12'hFFF = all LEDs off).
module hub75_scan #(
  parameter int NUM_COLS    = 64,
  parameter int HALF_ROWS   = 32,
  parameter int SHOW_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] rd_addr,
  input  logic [11:0] b_rdata0,
  input  logic [11:0] b_rdata1,
  output logic        LP_CLK,
  output logic        LATCH,
  output logic        NOE,
  output logic [4:0]  ROW,
  output logic [2:0]  RGB0,
  output logic [2:0]  RGB1,
  output logic        frame_done
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int ROW_W = $clog2(HALF_ROWS);
  localparam int CNT_W = $clog2((SHOW_CYCLES << 3) + 1);

  typedef enum logic [2:0] {
    S_ADDR,
    S_DATA,
    S_CLK,
    S_BLANK,
    S_LATCH,
    S_SHOW
  } state_t;

  state_t           state, state_next;
  logic [COL_W-1:0] col, col_inc;
  logic [ROW_W-1:0] row, row_after;
  logic [1:0]       plane;
  logic [CNT_W-1:0] show_cnt, show_len;
  logic             last_col, last_row, last_plane, show_done;

  // Pick the {B,G,R} bits of one bit plane out of a 12-bit pixel word.
  function automatic logic [2:0] plane_bits(input logic [11:0] word, input logic [1:0] p);
    logic [11:0] d;
`ifdef HUB75_INVERT_EN
    d = ~word;
`else
    d = word;
`endif
    return {d[{2'b10, p}], d[{2'b01, p}], d[{2'b00, p}]};
  endfunction

  assign last_col   = (col == COL_W'(NUM_COLS - 1));
  assign last_row   = (row == ROW_W'(HALF_ROWS - 1));
  assign last_plane = (plane == 2'd3);
  assign show_done  = (show_cnt == '0);
  assign col_inc    = last_col ? '0 : col + COL_W'(1);
  assign row_after  = !last_plane ? row : (last_row ? '0 : row + ROW_W'(1));
  assign show_len   = CNT_W'(SHOW_CYCLES) << plane;

  always_ff @(posedge clk) begin
    if (reset) state <= S_ADDR;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_next; no latch is inferred.
    state_next = state;
    unique case (state)
      S_ADDR:  state_next = S_DATA;
      S_DATA:  state_next = S_CLK;
      S_CLK:   state_next = last_col ? S_BLANK : S_ADDR;
      S_BLANK: state_next = S_LATCH;
      S_LATCH: state_next = S_SHOW;
      S_SHOW:  state_next = show_done ? S_ADDR : S_SHOW;
      default: state_next = S_ADDR;
    endcase
  end

  // The address for the next column is issued one state early so the memory's
  // one-cycle read lands exactly in S_DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr    <= '0;
      LP_CLK     <= 1'b0;
      LATCH      <= 1'b0;
      NOE        <= 1'b1;
      ROW        <= '0;
      RGB0       <= '0;
      RGB1       <= '0;
      frame_done <= 1'b0;
      row        <= '0;
      col        <= '0;
      plane      <= '0;
      show_cnt   <= '0;
    end else begin
      // NOTE: non-blocking for all registered state so every flop samples pre-edge values.
      frame_done <= 1'b0;
      unique case (state)
        S_ADDR: LP_CLK <= 1'b0;
        S_DATA: begin
          RGB0 <= plane_bits(b_rdata0, plane);
          RGB1 <= plane_bits(b_rdata1, plane);
        end
        S_CLK: begin
          LP_CLK  <= 1'b1;
          col     <= col_inc;
          rd_addr <= 12'({row, col_inc});
        end
        S_BLANK: begin
          LP_CLK <= 1'b0;
          NOE    <= 1'b1;
          LATCH  <= 1'b1;
          ROW    <= 5'(row);
        end
        S_LATCH: begin
          LATCH    <= 1'b0;
          NOE      <= 1'b0;
          show_cnt <= show_len - CNT_W'(1);
        end
        S_SHOW: begin
          if (show_done) begin
            NOE     <= 1'b1;
            plane   <= plane + 2'd1;
            row     <= row_after;
            rd_addr <= 12'({row_after, COL_W'(0)});
            if (last_plane && last_row) frame_done <= 1'b1;
          end else begin
            show_cnt <= show_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan.sv
// Self-checking bench for hub75_scan: timeline model of the scan checked every cycle plus literal pins.
// Honours HUB75_INVERT_EN the same way as the design.
module tb_hub75_scan;

  localparam int NC        = 64;
  localparam int HR        = 32;
  localparam int SC        = 32;
  localparam int SHIFT     = 3 * NC;
  localparam int ROW_LEN   = 4 * (SHIFT + 2) + SC * 15;
  localparam int FRAME_LEN = HR * ROW_LEN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] rd_addr;
  logic [11:0] b_rdata0 = '0;
  logic [11:0] b_rdata1 = '0;
  logic        LP_CLK, LATCH, NOE, frame_done;
  logic [4:0]  ROW;
  logic [2:0]  RGB0, RGB1;

  logic [11:0] mem0 [4096];
  logic [11:0] mem1 [4096];

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  hub75_scan dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .b_rdata0   (b_rdata0),
    .b_rdata1   (b_rdata1),
    .LP_CLK     (LP_CLK),
    .LATCH      (LATCH),
    .NOE        (NOE),
    .ROW        (ROW),
    .RGB0       (RGB0),
    .RGB1       (RGB1),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Memories with one cycle of read latency; k counts cycles since the scan (re)started.
  always @(posedge clk) begin
    b_rdata0 <= mem0[rd_addr];
    b_rdata1 <= mem1[rd_addr];
    k        <= reset ? 0 : k + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int plane_len(input int p);
    return SHIFT + 2 + (SC << p);
  endfunction

  function automatic logic [2:0] pix_bits(input logic [11:0] word, input int p);
    logic [11:0] d;
    logic [11:0] s;
`ifdef HUB75_INVERT_EN
    d = ~word;
`else
    d = word;
`endif
    s = d >> p;
    return {s[8], s[4], s[0]};
  endfunction

  // Timeline model: position inside the frame decides every output.
  int   edges = 0, run = 0, run_plane = 0;
  logic prev_lp = 1'b0, prev_noe = 1'b1;
  logic [4:0] prev_row = '0;

  always @(negedge clk) begin : compare
    int g, r, o, p, col, ph, ec, lat_row;
    bit e_lp, e_latch, e_noe, e_fd;
    g = k / ROW_LEN;
    r = g % HR;
    o = k % ROW_LEN;
    p = 0;
    while (p < 3 && o >= plane_len(p)) begin
      o = o - plane_len(p);
      p++;
    end
    col     = o / 3;
    ph      = o % 3;
    e_lp    = (o < SHIFT && ph == 0 && col > 0) || (o == SHIFT);
    e_latch = (o == SHIFT + 1);
    e_noe   = (o < SHIFT + 2);
    e_fd    = (k > 0 && k % FRAME_LEN == 0);
    lat_row = (p > 0 || o >= SHIFT + 1) ? r : ((g == 0) ? 0 : (g - 1) % HR);
    check("lp_clk", LP_CLK, e_lp);
    check("latch", LATCH, e_latch);
    check("noe", NOE, e_noe);
    check("row", ROW, lat_row);
    check("frame_done", frame_done, e_fd);
    if (o < SHIFT && ph == 0) check("rd_addr", rd_addr, r * NC + col);
    if (!reset) begin
      if (LP_CLK && !prev_lp && e_lp) begin
        ec = (o == SHIFT) ? NC - 1 : col - 1;
        edges++;
        check("rgb0", RGB0, pix_bits(mem0[r * NC + ec], p));
        check("rgb1", RGB1, pix_bits(mem1[r * NC + ec], p));
      end
      if (e_latch) begin
        check("lp_edges", edges, NC);
        edges = 0;
      end
      if (!NOE) run++;
      else if (run > 0) begin
        check("noe_run", run, SC << run_plane);
        run_plane = (run_plane + 1) % 4;
        run = 0;
      end
      if (ROW !== prev_row) check("row_change_noe", {prev_noe, NOE}, 2'b11);
    end else begin
      edges     = 0;
      run       = 0;
      run_plane = 0;
    end
    prev_lp  = LP_CLK;
    prev_noe = NOE;
    prev_row = ROW;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_k(input int target);
    for (int i = 0; i < FRAME_LEN + 2000 && k != target; i++) tick();
    check("wait_k", k, target);
  endtask

  task automatic wait_lp();
    for (int i = 0; i < 20 && !LP_CLK; i++) tick();
    check("first_lp_rise", LP_CLK, 1'b1);
  endtask

  task automatic fill(input logic [11:0] v0, input logic [11:0] v1);
    for (int a = 0; a < 4096; a++) begin
      mem0[a] = v0;
      mem1[a] = v1;
    end
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < 4096; a++) begin
      mem0[a] = 12'(a * 7) ^ 12'h5A3;
      mem1[a] = 12'(a) ^ 12'hC3C;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fill(12'h00F, 12'h0F0);
    repeat (5) tick();
    check("reset_noe", NOE, 1'b1);
    check("reset_latch", LATCH, 1'b0);
    check("reset_lp", LP_CLK, 1'b0);
    check("reset_row", ROW, 5'd0);
    check("reset_rgb", {RGB0, RGB1}, 6'd0);
    reset = 1'b0;
    check("first_rd_addr", rd_addr, 12'h000);

    // Column 0 of plane 0, row 0.
    wait_lp();
`ifdef HUB75_INVERT_EN
    check("a_rgb0_lit", RGB0, 3'b110);
    check("a_rgb1_lit", RGB1, 3'b101);
`else
    check("a_rgb0_lit", RGB0, 3'b001);
    check("a_rgb1_lit", RGB1, 3'b010);
`endif
    wait_k(189);
    check("last_col_addr", rd_addr, 12'h03F);
    for (int i = 0; i < FRAME_LEN + 100 && !frame_done; i++) tick();
    check("frame_done_k", k, 32'd40192);
    wait_k(FRAME_LEN + 1300);

    // Bit-plane and all-on/all-off data, then reset in S_SHOW of row 17 plane 2.
    reset = 1'b1;
    tick();
    fill(12'h005, 12'hFFF);
    repeat (2) tick();
    reset = 1'b0;
    wait_lp();
`ifdef HUB75_INVERT_EN
    check("b_rgb0_lit", RGB0, 3'b110);
    check("b_rgb1_lit", RGB1, 3'b000);
`else
    check("b_rgb0_lit", RGB0, 3'b001);
    check("b_rgb1_lit", RGB1, 3'b111);
`endif
    wait_k(17 * ROW_LEN + plane_len(0) + plane_len(1) + SHIFT + 2 + 10);
    check("noe_in_show", NOE, 1'b0);
    check("row_in_show", ROW, 5'd17);
    reset = 1'b1;
    tick();
    check("noe_after_reset", NOE, 1'b1);
    fill_pattern();
    tick();
    reset = 1'b0;
    check("restart_rd_addr", rd_addr, 12'h000);
    for (int i = 0; i < 300 && !LATCH; i++) tick();
    check("restart_latch", LATCH, 1'b1);
    check("restart_row", ROW, 5'd0);
    wait_k(1300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
